sd_cmd_arbiter: RTL

//  Shares the single SD/eMMC command master between two requesters: A (host register path) and B (auto-command engine, e.g. CMD12/CMD13).

---
 rtl/sd_cmd_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter sharing one SD/eMMC command master between requesters A and B.
// Optional WAIT watchdog is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_cmd_arbiter #(
   parameter int START_HOLD  = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        sd_clk,
   input  logic        rst,
   input  logic        i_req_a,
   input  logic        i_req_b,
   input  logic [1:0]  i_setting_a,
   input  logic [1:0]  i_setting_b,
   input  logic [39:0] i_cmd_a,
   input  logic [39:0] i_cmd_b,
   input  logic        i_busy_chk_a,
   input  logic        i_busy_chk_b,
   output logic        o_done_a,
   output logic        o_done_b,
   output logic [4:0]  o_status,
   output logic [31:0] o_rsp0,
   output logic [31:0] o_rsp1,
   output logic [31:0] o_rsp2,
   output logic [31:0] o_rsp3,
   output logic [1:0]  o_setting,
   output logic [39:0] o_cmd,
   output logic        o_busy_check,
   output logic        o_start_xfr,
   output logic        o_int_rst,
   input  logic [4:0]  i_int_status,
   input  logic [31:0] i_resp0,
   input  logic [31:0] i_resp1,
   input  logic [31:0] i_resp2,
   input  logic [31:0] i_resp3
);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_gnt_b;
   logic [3:0]  r_hold;
   logic [4:0]  r_status;
   logic [31:0] r_rsp0, r_rsp1, r_rsp2, r_rsp3;
   logic [1:0]  r_setting;
   logic [39:0] r_cmd;
   logic        r_busy_chk;
   logic        w_any_req;
   logic        w_grant_a;
   logic        w_cmpl;
   logic        w_tmo;

   assign w_any_req = i_req_a | i_req_b;
   // r_gnt_b doubles as last_gnt: on a tie, A wins unless A was served last
   assign w_grant_a = i_req_a & (~i_req_b | r_gnt_b);
   assign w_cmpl    = i_int_status[0] | i_int_status[1];

`ifdef SD_ARB_TIMEOUT_EN
   logic [15:0] r_wdog;

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst)
         r_wdog <= '0;
      else if (r_state == S_WAIT)
         r_wdog <= r_wdog + 16'd1;
      else
         r_wdog <= '0;
   end

   assign w_tmo = (r_state == S_WAIT) && (r_wdog == 16'(TIMEOUT_CYC - 1));
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC == 0);
   assign w_tmo        = 1'b0;
`endif

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_CLR;
         S_CLR:   w_next = S_START;
         S_START: if (r_hold == 4'd0) w_next = S_WAIT;
         S_WAIT:  if (w_cmpl || w_tmo) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_int_rst   = 1'b0;
      o_start_xfr = 1'b0;
      o_done_a    = 1'b0;
      o_done_b    = 1'b0;
      case (r_state)
         S_CLR:   o_int_rst   = 1'b1;
         S_START: o_start_xfr = 1'b1;
         S_DONE: begin
            o_done_a = ~r_gnt_b;
            o_done_b = r_gnt_b;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         r_gnt_b    <= 1'b1;
         r_hold     <= '0;
         r_status   <= '0;
         r_rsp0     <= '0;
         r_rsp1     <= '0;
         r_rsp2     <= '0;
         r_rsp3     <= '0;
         r_setting  <= '0;
         r_cmd      <= '0;
         r_busy_chk <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_any_req) begin
               r_gnt_b    <= ~w_grant_a;
               r_setting  <= w_grant_a ? i_setting_a  : i_setting_b;
               r_cmd      <= w_grant_a ? i_cmd_a      : i_cmd_b;
               r_busy_chk <= w_grant_a ? i_busy_chk_a : i_busy_chk_b;
            end
            S_CLR:   r_hold <= 4'(START_HOLD - 1);
            S_START: r_hold <= r_hold - 4'd1;
            S_WAIT: begin
               // master completion wins over a watchdog expiry in the same cycle
               if (w_cmpl) begin
                  r_status <= i_int_status;
                  r_rsp0   <= i_resp0;
                  r_rsp1   <= i_resp1;
                  r_rsp2   <= i_resp2;
                  r_rsp3   <= i_resp3;
               end else if (w_tmo) begin
                  r_status <= 5'b00110;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_status     = r_status;
   assign o_rsp0       = r_rsp0;
   assign o_rsp1       = r_rsp1;
   assign o_rsp2       = r_rsp2;
   assign o_rsp3       = r_rsp3;
   assign o_setting    = r_setting;
   assign o_cmd        = r_cmd;
   assign o_busy_check = r_busy_chk;

endmodule
